bus_pattern_gen: RTL and testbench
==================================

Name: bus_pattern_gen

Overview:
Parametrised bus test-pattern generator driving a WIDTH-bit output bus. Generalises the fixed 10-bit cumulative-fill generator in four ways: runtime-selectable pattern mode, start/stop/pause control, single-pass or continuous operation, and a pass-complete pulse. It is used as the stimulus source for bus and pin-connectivity tests on board bring-up and in simulation.

Parameters:
WIDTH, 10, output bus width in bits; legal range 2..32; elaboration error outside that range.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous reset, active-high
START  input  1  begins a pass from IDLE or DONE; ignored in RUN
STOP  input  1  synchronous abort to IDLE
EN  input  1  advance enable in RUN; low pauses the generator
MODE  input  2  pattern mode, sampled only when START is accepted
CONT  input  1  1 = continuous passes; 0 = single pass then DONE
BUS_OUT  output  WIDTH  registered pattern
BUSY  output  1  high in RUN
PASS_DONE  output  1  one-cycle pulse when the last pattern of a pass is on BUS_OUT

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, BUS_OUT=0, BUSY=0, PASS_DONE=0, step counter=0, latched mode=0.
- States:
  - IDLE, RUN, DONE; 2-bit registered encoding.
  - All outputs are registered, and BUSY is 1 exactly when state=RUN.
- Modes (latched on accept), with the first pattern P0 and the next pattern for each:
  - 0 FILL: P0=1. next = BUS_OUT | (1<<step). Pass length WIDTH.
  - 1 WALK1: P0=1. next = 1<<step. Pass length WIDTH.
  - 2 WALK0: P0 = ~1. next = ~(1<<step). Pass length WIDTH.
  - 3 COUNT: P0=0. next = BUS_OUT+1 (mod 2^WIDTH). Pass length 2^WIDTH.
- Step counter:
  - WIDTH bits, giving the index of the pattern currently on BUS_OUT.
  - Last pattern is at step = pass length−1.
- IDLE/DONE -> RUN:
  - START=1 and STOP=0 at an edge: next edge loads BUS_OUT=P0, step=0, state=RUN, and latches MODE.
  - Latency from START sampled to P0 visible is 1 cycle.
- RUN, EN=1, not last step: step+1 and BUS_OUT=next each edge.
- RUN, EN=0: BUS_OUT, step and state hold; PASS_DONE=0.
- PASS_DONE:
  - Registered together with the last pattern, so it is high for exactly the one cycle in which the last pattern first appears.
  - It is not reasserted while paused on the last pattern.
- RUN, EN=1, at last step:
  - CONT=1: BUS_OUT=P0, step=0, stay RUN. FILL mode restarts from 1, not accumulated.
  - CONT=0: state=DONE, BUS_OUT holds the last pattern, BUSY=0.
- DONE: holds BUS_OUT until START (new pass) or STOP.
- STOP=1, any state: next edge goes to IDLE, BUS_OUT=0, PASS_DONE=0. STOP has priority over START and EN.
- MODE/CONT changes mid-pass: MODE is ignored until the next accepted START. CONT is sampled live at the last step.
- Reset mid-pass: immediate return to the reset values; no pulse is emitted.

Optional Feature:
Macro BUS_PATTERN_LOOPBACK_CHECK_EN.
- Defined:
  - Adds input BUS_IN[WIDTH-1:0] and output ERR_CNT[15:0].
  - BUS_IN is compared against BUS_OUT delayed by one register (loopback latency 1).
  - The compare is enabled only when the delayed copy corresponds to a RUN cycle.
  - Each mismatch increments ERR_CNT, saturating at 0xFFFF.
  - ERR_CNT clears on RST and on an accepted START.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package bus_pattern_pkg:
  - Mode constants MODE_FILL=0, MODE_WALK1=1, MODE_WALK0=2, MODE_COUNT=3.
  - State constants ST_IDLE, ST_RUN, ST_DONE.
- Sub-module bus_loop_checker: delay register, compare and saturating counter; instantiated only under the macro.
- Next-pattern selection stays inline in the top.

Test Plan:
- FILL, WIDTH=10, CONT=0, EN=1: START -> BUS_OUT 0x001,0x003,0x007,…,0x3FF. PASS_DONE with 0x3FF, then DONE holding 0x3FF with BUSY=0.
- WALK0, CONT=1: START -> 0x3FE,0x3FD,…,0x1FF, then 0x3FE. PASS_DONE every 10 cycles.
- COUNT, CONT=0: START -> 0x000..0x3FF over 1024 cycles. One PASS_DONE at 0x3FF.
- WALK1: drop EN for 3 cycles at 0x008 -> 0x008 holds, step holds. EN=1 -> 0x010 next. Paused on last step -> PASS_DONE is not repeated.
- STOP and START in the same cycle during RUN -> IDLE, BUS_OUT=0. Assert RST mid-pass -> outputs zero asynchronously.
- With BUS_PATTERN_LOOPBACK_CHECK_EN: loop BUS_OUT→BUS_IN through a 1-cycle register, and corrupt bit 2 for 2 cycles -> ERR_CNT=2. Next START -> ERR_CNT=0.

Source files
------------

// File: rtl/bus_pattern_pkg.sv
// Shared types and constants for the bus test-pattern generator.
//   Mode encoding (MODE_*), controller state encoding (ST_*),
//   loopback error-counter width.
package bus_pattern_pkg;

    localparam int unsigned MODE_W    = 2;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned ERR_CNT_W = 16;

    typedef enum logic [MODE_W-1:0] {
        MODE_FILL  = 2'd0,
        MODE_WALK1 = 2'd1,
        MODE_WALK0 = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bus_loop_checker.sv
// Loopback checker: delays the generated pattern by one register and compares
// it with the returned bus, counting mismatches with saturation.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   CLR             synchronous clear of the error counter
//   PAT, PAT_VLD    pattern currently driven and whether it is a RUN cycle
//   BUS_IN          looped-back bus (expected one cycle behind PAT)
//   ERR_CNT         saturating mismatch count
module bus_loop_checker
    import bus_pattern_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLR,
    input  logic [WIDTH-1:0]     PAT,
    input  logic                 PAT_VLD,
    input  logic [WIDTH-1:0]     BUS_IN,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    logic [WIDTH-1:0] pat_q;
    logic             vld_q;
    logic             mismatch;

    // Only cycles that followed a RUN cycle carry a pattern worth checking.
    assign mismatch = vld_q && (BUS_IN != pat_q);

    // Delay register plus saturating counter; a clear beats a same-cycle miss.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pat_q   <= '0;
            vld_q   <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            pat_q <= PAT;
            vld_q <= PAT_VLD;
            if (CLR) begin
                ERR_CNT <= '0;
            end else if (mismatch && !(&ERR_CNT)) begin
                ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bus_pattern_gen.sv
// Parametrised bus test-pattern generator (fill, walking-1, walking-0, count)
// with start/stop/pause control, single or continuous passes and a
// pass-complete pulse.
// Optional loopback checker enabled by macro BUS_PATTERN_LOOPBACK_CHECK_EN.
// Ports:
//   CLK, RST    clock, asynchronous active-high reset
//   START       begin a pass from IDLE/DONE (ignored in RUN)
//   STOP        synchronous abort to IDLE, highest priority
//   EN          advance enable while running
//   MODE        pattern mode, latched when START is accepted
//   CONT        continuous passes when high, sampled at the last step
//   BUS_IN      (macro only) looped-back bus
//   ERR_CNT     (macro only) saturating loopback mismatch count
//   BUS_OUT     registered pattern
//   BUSY        high while running
//   PASS_DONE   one-cycle pulse with the last pattern of a pass
module bus_pattern_gen
    import bus_pattern_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 EN,
    input  logic [MODE_W-1:0]    MODE,
    input  logic                 CONT,
`ifdef BUS_PATTERN_LOOPBACK_CHECK_EN
    input  logic [WIDTH-1:0]     BUS_IN,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
`endif
    output logic [WIDTH-1:0]     BUS_OUT,
    output logic                 BUSY,
    output logic                 PASS_DONE
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("bus_pattern_gen: WIDTH must be in 2..32");
    end

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    mode_t            mode_q;
    logic [WIDTH-1:0] step_q;

    logic [WIDTH-1:0] step_nxt;
    logic [WIDTH-1:0] bit_nxt;
    logic [WIDTH-1:0] pat_nxt;
    logic [WIDTH-1:0] last_step;
    logic             at_last;

    // First pattern of a pass for a given mode.
    function automatic logic [WIDTH-1:0] first_pat(input mode_t m);
        case (m)
            MODE_WALK0: first_pat = ~ONE;
            MODE_COUNT: first_pat = '0;
            default:    first_pat = ONE;
        endcase
    endfunction

    // The shift uses the index of the pattern about to be shown.
    assign step_nxt  = step_q + ONE;
    assign bit_nxt   = ONE << step_nxt;
    assign last_step = (mode_q == MODE_COUNT) ? '1 : WIDTH'(WIDTH - 1);
    assign at_last   = (step_q == last_step);

    // Next pattern within a pass for the latched mode.
    always_comb begin
        pat_nxt = BUS_OUT;
        case (mode_q)
            MODE_FILL:  pat_nxt = BUS_OUT | bit_nxt;
            MODE_WALK1: pat_nxt = bit_nxt;
            MODE_WALK0: pat_nxt = ~bit_nxt;
            MODE_COUNT: pat_nxt = BUS_OUT + ONE;
            default:    pat_nxt = BUS_OUT;
        endcase
    end

    // Controller: STOP first, then START from IDLE/DONE, then advance in RUN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_FILL;
            step_q    <= '0;
            BUS_OUT   <= '0;
            BUSY      <= 1'b0;
            PASS_DONE <= 1'b0;
        end else begin
            PASS_DONE <= 1'b0;
            if (STOP) begin
                state   <= ST_IDLE;
                step_q  <= '0;
                BUS_OUT <= '0;
                BUSY    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (START) begin
                            state   <= ST_RUN;
                            mode_q  <= mode_t'(MODE);
                            step_q  <= '0;
                            BUS_OUT <= first_pat(mode_t'(MODE));
                            BUSY    <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (EN) begin
                            if (at_last) begin
                                if (CONT) begin
                                    // Restart from P0 rather than accumulating.
                                    step_q  <= '0;
                                    BUS_OUT <= first_pat(mode_q);
                                end else begin
                                    state <= ST_DONE;
                                    BUSY  <= 1'b0;
                                end
                            end else begin
                                step_q    <= step_nxt;
                                BUS_OUT   <= pat_nxt;
                                PASS_DONE <= (step_nxt == last_step);
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        step_q  <= '0;
                        BUS_OUT <= '0;
                        BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BUS_PATTERN_LOOPBACK_CHECK_EN
    logic start_acc;

    // Same acceptance condition the controller uses; clears the error count.
    assign start_acc = START && !STOP && (state != ST_RUN);

    bus_loop_checker #(
        .WIDTH (WIDTH)
    ) u_loop_checker (
        .CLK     (CLK),
        .RST     (RST),
        .CLR     (start_acc),
        .PAT     (BUS_OUT),
        .PAT_VLD (BUSY),
        .BUS_IN  (BUS_IN),
        .ERR_CNT (ERR_CNT)
    );
`endif

endmodule

// File: tb/tb_bus_pattern_gen.sv
// Directed self-checking bench for bus_pattern_gen at WIDTH=10.
module tb_bus_pattern_gen;

    localparam int unsigned WIDTH = 10;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic             STOP;
    logic             EN;
    logic [1:0]       MODE;
    logic             CONT;
    logic [WIDTH-1:0] BUS_OUT;
    logic             BUSY;
    logic             PASS_DONE;

    int n_vec = 0;
    int n_err = 0;

`ifdef BUS_PATTERN_LOOPBACK_CHECK_EN
    logic [WIDTH-1:0] BUS_IN;
    logic [15:0]      ERR_CNT;
    logic [WIDTH-1:0] inj = '0;

    // External one-cycle loopback with optional corruption.
    always @(posedge CLK or posedge RST) begin
        if (RST) BUS_IN <= '0;
        else     BUS_IN <= BUS_OUT ^ inj;
    end
`endif

    bus_pattern_gen #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .STOP      (STOP),
        .EN        (EN),
        .MODE      (MODE),
        .CONT      (CONT),
`ifdef BUS_PATTERN_LOOPBACK_CHECK_EN
        .BUS_IN    (BUS_IN),
        .ERR_CNT   (ERR_CNT),
`endif
        .BUS_OUT   (BUS_OUT),
        .BUSY      (BUSY),
        .PASS_DONE (PASS_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] bus, input logic busy, input logic pd);
        check({tag, ".bus"},  32'(BUS_OUT),   bus);
        check({tag, ".busy"}, 32'(BUSY),      32'(busy));
        check({tag, ".pd"},   32'(PASS_DONE), 32'(pd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pd_cnt;
        logic [31:0] exp;

        RST = 1'b1; START = 1'b0; STOP = 1'b0; EN = 1'b1; MODE = 2'd0; CONT = 1'b0;
        #2;
        check_out("reset", 32'h000, 1'b0, 1'b0);
        #20 RST = 1'b0;
        tick();
        check_out("idle", 32'h000, 1'b0, 1'b0);

        // FILL single pass
        MODE = 2'd0; CONT = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        check_out("fill0", 32'h001, 1'b1, 1'b0);
        for (int i = 1; i < 10; i++) begin
            tick();
            exp = (32'd1 << (i + 1)) - 32'd1;
            check_out($sformatf("fill%0d", i), exp, 1'b1, i == 9);
        end
        tick();
        check_out("fill_done", 32'h3FF, 1'b0, 1'b0);
        tick();
        check_out("fill_hold", 32'h3FF, 1'b0, 1'b0);

        // WALK0 continuous, started from DONE
        MODE = 2'd2; CONT = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        check_out("walk0_0", 32'h3FE, 1'b1, 1'b0);
        for (int i = 1; i < 25; i++) begin
            tick();
            exp = ~(32'd1 << (i % 10)) & 32'h3FF;
            check_out($sformatf("walk0_%0d", i), exp, 1'b1, (i % 10) == 9);
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        check_out("walk0_stop", 32'h000, 1'b0, 1'b0);

        // COUNT single pass; MODE change mid-pass must be ignored
        MODE = 2'd3; CONT = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        MODE = 2'd1;
        check_out("count0", 32'h000, 1'b1, 1'b0);
        pd_cnt = 0;
        for (int i = 1; i < 1024; i++) begin
            tick();
            if (PASS_DONE) pd_cnt++;
            if (i == 1 || i == 255 || i == 256 || i == 1023)
                check_out($sformatf("count%0d", i), 32'(i), 1'b1, i == 1023);
            else
                check($sformatf("count%0d.bus", i), 32'(BUS_OUT), 32'(i));
        end
        check("count_pd_pulses", 32'(pd_cnt), 32'd1);
        tick();
        check_out("count_done", 32'h3FF, 1'b0, 1'b0);

        // WALK1 with pause mid-pass and on the last step
        MODE = 2'd1; CONT = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        check_out("walk1_0", 32'h001, 1'b1, 1'b0);
        tick(); check_out("walk1_1", 32'h002, 1'b1, 1'b0);
        tick(); check_out("walk1_2", 32'h004, 1'b1, 1'b0);
        tick(); check_out("walk1_3", 32'h008, 1'b1, 1'b0);
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("walk1_pause%0d", i), 32'h008, 1'b1, 1'b0);
        end
        EN = 1'b1;
        tick(); check_out("walk1_4", 32'h010, 1'b1, 1'b0);
        tick(); check_out("walk1_5", 32'h020, 1'b1, 1'b0);
        tick(); check_out("walk1_6", 32'h040, 1'b1, 1'b0);
        tick(); check_out("walk1_7", 32'h080, 1'b1, 1'b0);
        tick(); check_out("walk1_8", 32'h100, 1'b1, 1'b0);
        tick(); check_out("walk1_9", 32'h200, 1'b1, 1'b1);
        EN = 1'b0;
        tick(); check_out("walk1_lastpause0", 32'h200, 1'b1, 1'b0);
        tick(); check_out("walk1_lastpause1", 32'h200, 1'b1, 1'b0);
        // CONT raised while paused on the last step takes effect live
        CONT = 1'b1; EN = 1'b1;
        tick(); check_out("walk1_wrap", 32'h001, 1'b1, 1'b0);

        // STOP and START together during RUN
        STOP = 1'b1; START = 1'b1;
        tick();
        check_out("stop_start", 32'h000, 1'b0, 1'b0);
        STOP = 1'b0; START = 1'b0;
        tick();
        check_out("stop_idle", 32'h000, 1'b0, 1'b0);

        // Asynchronous reset mid-pass
        MODE = 2'd3; CONT = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        check_out("rst_pre", 32'h003, 1'b1, 1'b0);
        #2 RST = 1'b1;
        #1;
        check_out("rst_async", 32'h000, 1'b0, 1'b0);
        #10 RST = 1'b0;
        tick();
        check_out("rst_after", 32'h000, 1'b0, 1'b0);

`ifdef BUS_PATTERN_LOOPBACK_CHECK_EN
        // Loopback: corrupt bit 2 for two RUN cycles, then restart clears
        MODE = 2'd0; CONT = 1'b1; EN = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick();
        check("lb_clean", 32'(ERR_CNT), 32'd0);
        inj = 10'h004;
        tick(); tick();
        inj = '0;
        tick(); tick(); tick();
        check("lb_errs", 32'(ERR_CNT), 32'd2);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        tick();
        check("lb_hold", 32'(ERR_CNT), 32'd2);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("lb_clear", 32'(ERR_CNT), 32'd0);
        tick(); tick();
        check("lb_clear_run", 32'(ERR_CNT), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
